// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// instruction field layout.
package cpu_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_IDX_W = 2;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS_MSB  = 9;
    localparam int unsigned RS_LSB  = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADDI = 4'h3,
        OP_JMP  = 4'h4,
        OP_JZ   = 4'h5,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_e;

    typedef struct packed {
        opcode_e               opcode;
        logic [REG_IDX_W-1:0]  rd;
        logic [REG_IDX_W-1:0]  rs;
        logic [7:0]            imm8;
    } instr_t;

    function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] raw);
        instr_t f;
        f.opcode = opcode_e'(raw[OPC_MSB:OPC_LSB]);
        f.rd     = raw[RD_MSB:RD_LSB];
        f.rs     = raw[RS_MSB:RS_LSB];
        f.imm8   = raw[IMM_MSB:IMM_LSB];
        return f;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode and ALU: turns the latched instruction plus the rs
// operand into a register write request and a branch decision.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0]   ir_i,
    input  logic [DATA_W-1:0]    read_data_i,
    output logic                 wr_en_o,
    output logic [REG_IDX_W-1:0] wr_idx_o,
    output logic [DATA_W-1:0]    wr_data_o,
    output logic [ADDR_W-1:0]    branch_target_o,
    output logic                 branch_taken_o,
    output logic                 halt_o,
    output logic                 illegal_o
);

    instr_t            f;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_sext;

    assign f        = unpack_instr(ir_i);
    assign imm_zext = {8'h00, f.imm8};
    assign imm_sext = {{8{f.imm8[7]}}, f.imm8};

    assign branch_target_o = f.imm8;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        wr_en_o        = 1'b0;
        wr_idx_o       = '0;
        wr_data_o      = '0;
        branch_taken_o = 1'b0;
        halt_o         = 1'b0;
        illegal_o      = 1'b0;
        case (f.opcode)
            OP_NOP: ;
            OP_LDI: begin
                wr_en_o   = 1'b1;
                wr_idx_o  = f.rd;
                wr_data_o = imm_zext;
            end
            OP_MOV: begin
                wr_en_o   = 1'b1;
                wr_idx_o  = f.rd;
                wr_data_o = read_data_i;
            end
            OP_ADDI: begin
                wr_en_o   = 1'b1;
                wr_idx_o  = f.rd;
                wr_data_o = read_data_i + imm_sext;
            end
            OP_JMP:  branch_taken_o = 1'b1;
            OP_JZ:   branch_taken_o = (read_data_i == '0);
            OP_HALT: halt_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH / DECODE / EXEC loop over an
// external instruction port and a 4-entry register file port.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 instr_req,
    output logic [ADDR_W-1:0]    instr_addr,
    input  logic                 instr_ack,
    input  logic [INSTR_W-1:0]   instr_data,
    output logic [REG_IDX_W-1:0] read_index_a,
    input  logic [DATA_W-1:0]    read_data_a,
    output logic [REG_IDX_W-1:0] write_index,
    output logic                 write_enable,
    output logic [DATA_W-1:0]    write_data,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted,
    output logic                 illegal
);

    state_e               state_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [ADDR_W-1:0]    pc_d;
    logic [INSTR_W-1:0]   ir_q;
    logic                 illegal_q;

    logic                 dec_wr_en;
    logic [REG_IDX_W-1:0] dec_wr_idx;
    logic [DATA_W-1:0]    dec_wr_data;
    logic [ADDR_W-1:0]    dec_target;
    logic                 dec_taken;
    logic                 dec_halt;
    logic                 dec_illegal;
    instr_t               ir_f;

    assign ir_f = unpack_instr(ir_q);
    assign pc_d = pc_q + 8'd1;

    instr_decode u_decode (
        .ir_i            (ir_q),
        .read_data_i     (read_data_a),
        .wr_en_o         (dec_wr_en),
        .wr_idx_o        (dec_wr_idx),
        .wr_data_o       (dec_wr_data),
        .branch_target_o (dec_target),
        .branch_taken_o  (dec_taken),
        .halt_o          (dec_halt),
        .illegal_o       (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (instr_ack) begin
                        ir_q    <= instr_data;
                        pc_q    <= pc_d;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: state_q <= ST_EXEC;
                ST_EXEC: begin
                    if (dec_taken)   pc_q      <= dec_target;
                    if (dec_illegal) illegal_q <= 1'b1;
                    state_q <= dec_halt ? ST_HALT : ST_FETCH;
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the port outputs are decoded from the registered state but gated
    // by reset, so asserting reset in EXEC suppresses the write on that edge.
    logic in_fetch;
    logic in_operand;
    logic in_exec;

    assign in_fetch   = reset && (state_q == ST_FETCH);
    assign in_operand = reset && (state_q == ST_DECODE || state_q == ST_EXEC);
    assign in_exec    = reset && (state_q == ST_EXEC);

    assign instr_req    = in_fetch;
    assign instr_addr   = pc_q;
    assign read_index_a = in_operand ? ir_f.rs : '0;
    assign write_enable = in_exec && dec_wr_en;
    assign write_index  = write_enable ? dec_wr_idx : '0;
    assign write_data   = write_enable ? dec_wr_data : '0;
    assign pc           = pc_q;
    assign halted       = (state_q == ST_HALT);
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised scoreboard bench for instr_sequencer: an ISA-level model predicts
// fetch addresses and register writes; monitors compare against the DUT.
module tb_instr_sequencer;

    localparam logic [7:0] RST_PC = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_ack;
    logic [15:0] instr_data;
    logic [1:0]  read_index_a;
    logic [15:0] read_data_a;
    logic [1:0]  write_index;
    logic        write_enable;
    logic [15:0] write_data;
    logic [7:0]  pc;
    logic        halted;
    logic        illegal;

    instr_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_ack    (instr_ack),
        .instr_data   (instr_data),
        .read_index_a (read_index_a),
        .read_data_a  (read_data_a),
        .write_index  (write_index),
        .write_enable (write_enable),
        .write_data   (write_data),
        .pc           (pc),
        .halted       (halted),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] imem [256];
    logic [15:0] init_regs [4];
    logic [15:0] rf [4];

    logic [7:0]  exp_fetch [$];
    logic [17:0] exp_wr [$];
    logic [15:0] m_regs [4];
    logic [7:0]  m_pc;
    logic        m_illegal;

    bit drv_en = 1'b0;
    bit mon_en = 1'b0;
    int fixed_delay = 0;
    int ack_max = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment register file: combinational read, write on clock edge.
    assign read_data_a = rf[read_index_a];
    always @(posedge clk) begin
        if (write_enable) rf[write_index] <= write_data;
        else if (!reset) for (int i = 0; i < 4; i++) rf[i] <= init_regs[i];
    end

    // ISA-level reference: walks the program and records what must be seen.
    task automatic run_model();
        logic [15:0] r [4];
        logic [7:0]  p;
        logic [15:0] ins;
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [7:0]  imm;
        for (int i = 0; i < 4; i++) r[i] = init_regs[i];
        p = RST_PC;
        m_illegal = 1'b0;
        exp_fetch.delete();
        exp_wr.delete();
        for (int step = 0; step < 1000; step++) begin
            exp_fetch.push_back(p);
            ins = imem[p];
            p   = p + 8'd1;
            op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
            if (op == 4'hF) break;
            case (op)
                4'h0: ;
                4'h1: begin r[rd] = {8'h00, imm}; exp_wr.push_back({rd, r[rd]}); end
                4'h2: begin r[rd] = r[rs]; exp_wr.push_back({rd, r[rd]}); end
                4'h3: begin r[rd] = r[rs] + {{8{imm[7]}}, imm}; exp_wr.push_back({rd, r[rd]}); end
                4'h4: p = imm;
                4'h5: if (r[rs] == 16'h0000) p = imm;
                default: m_illegal = 1'b1;
            endcase
        end
        m_pc = p;
        for (int i = 0; i < 4; i++) m_regs[i] = r[i];
    endtask

    // Instruction memory responder; also checks the held request while stalled.
    initial begin
        logic [7:0] a;
        logic [7:0] e;
        int d;
        instr_ack  = 1'b0;
        instr_data = 16'h0000;
        forever begin
            @(negedge clk);
            instr_ack  = 1'b0;
            instr_data = 16'($urandom);
            if (drv_en && instr_req) begin
                a = instr_addr;
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, ack_max));
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    instr_data = 16'($urandom);
                    check("req_held", {31'd0, instr_req}, 32'd1);
                    check("addr_stable", {24'd0, instr_addr}, {24'd0, a});
                    check("no_write_in_fetch", {31'd0, write_enable}, 32'd0);
                end
                if (mon_en) begin
                    n_tests++;
                    if (exp_fetch.size() == 0) begin
                        n_fail++;
                        $display("FAIL fetch_unexpected: got addr %h expected no fetch", a);
                    end else begin
                        e = exp_fetch.pop_front();
                        if (a !== e) begin
                            n_fail++;
                            $display("FAIL fetch_addr: got %h expected %h", a, e);
                        end
                    end
                end
                instr_data = imem[a];
                instr_ack  = 1'b1;
            end else if (drv_en && ($urandom % 4 == 0)) begin
                instr_ack = 1'b1;
            end
        end
    end

    // Write-port monitor.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (write_enable) begin
                    n_tests++;
                    if (exp_wr.size() == 0) begin
                        n_fail++;
                        $display("FAIL write_unexpected: got r%0d=%h expected no write", write_index, write_data);
                    end else begin
                        e = exp_wr.pop_front();
                        if ({write_index, write_data} !== e) begin
                            n_fail++;
                            $display("FAIL write: got r%0d=%h expected r%0d=%h",
                                     write_index, write_data, e[17:16], e[15:0]);
                        end
                    end
                end else begin
                    check("write_idle_zero", {14'd0, write_index, write_data}, 32'd0);
                end
                if (instr_req) check("rd_idx_in_fetch", {30'd0, read_index_a}, 32'd0);
                if (halted) check("halt_quiet", {30'd0, instr_req, write_enable}, 32'd0);
            end
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
        for (int i = 0; i < 4; i++) init_regs[i] = 16'h0000;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_instr_req", {31'd0, instr_req}, 32'd0);
        check("rst_write", {13'd0, write_enable, write_index, write_data}, 32'd0);
        check("rst_read_idx", {30'd0, read_index_a}, 32'd0);
        check("rst_pc", {24'd0, pc}, {24'd0, RST_PC});
        check("rst_flags", {30'd0, halted, illegal}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_no_req", {31'd0, instr_req}, 32'd0);
    endtask

    task automatic run_program(input int delay, output int cycles);
        run_model();
        fixed_delay = delay;
        apply_reset();
        drv_en = 1'b1;
        mon_en = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 0;
        while (!halted && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            start = ($urandom % 5 == 0);
        end
        start = 1'b0;
        check("halt_reached", {31'd0, halted}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("fetch_left", exp_fetch.size(), 32'd0);
        check("write_left", exp_wr.size(), 32'd0);
        check("final_pc", {24'd0, pc}, {24'd0, m_pc});
        check("final_illegal", {31'd0, illegal}, {31'd0, m_illegal});
        for (int i = 0; i < 4; i++) check($sformatf("final_r%0d", i), {16'd0, rf[i]}, {16'd0, m_regs[i]});
        mon_en = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic gen_random();
        int len;
        logic [3:0] ops [16];
        logic [3:0] op;
        logic [7:0] imm;
        ops = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h3,
                4'h4, 4'h5, 4'h5, 4'h5, 4'h7, 4'h9, 4'hE, 4'hF};
        clear_imem();
        len = $urandom_range(6, 24);
        for (int a = 0; a < len - 1; a++) begin
            op  = ops[$urandom % 16];
            imm = 8'($urandom);
            if (op == 4'h4 || op == 4'h5) imm = 8'($urandom_range(a + 1, len - 1));
            imem[a] = {op, 2'($urandom), 2'($urandom), imm};
        end
        imem[len - 1] = {4'hF, 12'($urandom)};
        for (int i = 0; i < 4; i++) begin
            case ($urandom % 4)
                0:       init_regs[i] = 16'h0000;
                1:       init_regs[i] = 16'hFFFF;
                default: init_regs[i] = 16'($urandom);
            endcase
        end
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) rf[i] = 16'h0000;

        // LDI r1,0x05 ; ADDI r2,r1,0xFF ; HALT
        clear_imem();
        imem[0] = 16'h1405; imem[1] = 16'h39FF; imem[2] = 16'hF000;
        run_program(0, cyc);
        check("halt_latency", cyc, 32'd9);
        check("r1_value", {16'd0, rf[1]}, 32'h0005);
        check("r2_value", {16'd0, rf[2]}, 32'h0004);

        // ADDI r0,r3,0x01 with r3 = 0xFFFF wraps to zero
        clear_imem();
        imem[0] = 16'h3301; imem[1] = 16'hF000;
        init_regs[0] = 16'hABCD; init_regs[3] = 16'hFFFF;
        run_program(0, cyc);
        check("addi_wrap", {16'd0, rf[0]}, 32'h0000);

        // JZ r2,0x40 taken, then not taken after r2 becomes 1
        clear_imem();
        imem[8'h00] = 16'h5240; imem[8'h40] = 16'h1801;
        imem[8'h41] = 16'h5240; imem[8'h42] = 16'hF000;
        run_program(0, cyc);

        // pc wrap 0xFF -> 0x00 and an illegal opcode
        clear_imem();
        imem[8'h00] = 16'h50FE; imem[8'hFE] = 16'h1001; imem[8'hFF] = 16'h0000;
        imem[8'h01] = 16'h7123; imem[8'h02] = 16'hF000;
        run_program(0, cyc);
        check("illegal_set", {31'd0, illegal}, 32'd1);

        // Acknowledge held off four cycles on every fetch
        clear_imem();
        imem[0] = 16'h1405; imem[1] = 16'h39FF; imem[2] = 16'hF000;
        run_program(4, cyc);

        // Reset asserted during EXEC of LDI aborts the write
        clear_imem();
        imem[0] = 16'h145A; imem[1] = 16'hF000;
        init_regs[1] = 16'h1111;
        fixed_delay = 0;
        apply_reset();
        drv_en = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 20 && !write_enable; k++) begin
            @(posedge clk);
            #1;
        end
        check("exec_reached", {31'd0, write_enable}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_exec_write", {13'd0, write_enable, write_index, write_data}, 32'd0);
        check("rst_exec_outs", {29'd0, instr_req, read_index_a}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_exec_pc", {24'd0, pc}, {24'd0, RST_PC});
        check("rst_exec_r1", {16'd0, rf[1]}, 32'h1111);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_exec_idle", {30'd0, instr_req, halted}, 32'd0);
        drv_en = 1'b0;

        // Random forward-branching programs with random fetch latency
        ack_max = 3;
        for (int t = 0; t < 20; t++) begin
            gen_random();
            run_program(-1, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
